// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: word/line widths and the pmem arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_icache = 2'd1,
    s_dcache = 2'd2
  } pmem_arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares the physical-memory port between I-cache and D-cache; one grant held until pmem_resp.
// Optional PMEM_ARB_ROUND_ROBIN_EN: alternate ties; default build gives ties to the D-cache.
module pmem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,

  input  logic          icache_pmem_read,
  input  logic [15:0]   icache_pmem_address,
  output logic [127:0]  icache_pmem_rdata,
  output logic          icache_pmem_resp,

  input  logic          dcache_pmem_read,
  input  logic          dcache_pmem_write,
  input  logic [15:0]   dcache_pmem_address,
  input  logic [127:0]  dcache_pmem_wdata,
  output logic [127:0]  dcache_pmem_rdata,
  output logic          dcache_pmem_resp,

  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  pmem_arb_state_t state_q, state_d;
  logic            ic_req, dc_req, dc_wins_tie;

  assign ic_req = icache_pmem_read;
  assign dc_req = dcache_pmem_read | dcache_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // 1 = D-cache was granted last; reset to "icache" so the first tie goes to the D-cache.
  logic last_dc_q, last_dc_d;

  always_comb begin
    last_dc_d = last_dc_q;
    if (state_q == s_idle && state_d == s_dcache) last_dc_d = 1'b1;
    if (state_q == s_idle && state_d == s_icache) last_dc_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_dc_q <= 1'b0;
    else          last_dc_q <= last_dc_d;
  end

  assign dc_wins_tie = ~last_dc_q;
`else
  assign dc_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= s_idle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_idle: begin
        if (ic_req && dc_req) state_d = dc_wins_tie ? s_dcache : s_icache;
        else if (dc_req)      state_d = s_dcache;
        else if (ic_req)      state_d = s_icache;
      end
      s_icache: if (pmem_resp) state_d = s_idle;
      s_dcache: if (pmem_resp) state_d = s_idle;
      default:  state_d = s_idle;
    endcase
  end

  // Command mux follows the owner; responses only reach the granted cache.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    unique case (state_q)
      s_icache: begin
        pmem_read        = icache_pmem_read;
        pmem_address     = icache_pmem_address;
        icache_pmem_resp = pmem_resp;
      end
      s_dcache: begin
        pmem_read        = dcache_pmem_read;
        pmem_write       = dcache_pmem_write;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        dcache_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Table-driven bench for pmem_arbiter with an expected-output queue, plus reset and tie sequences.
module tb_pmem_arbiter;

  typedef struct {
    logic         icr;
    logic [15:0]  ica;
    logic         dcr;
    logic         dcw;
    logic [15:0]  dca;
    logic [127:0] dcwd;
    logic [127:0] prd;
    logic         presp;
    logic         e_rd;
    logic         e_wr;
    logic [15:0]  e_addr;
    logic [127:0] e_wd;
    logic         e_ir;
    logic         e_dr;
  } vec_t;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    logic [127:0] rdata;
    logic         ir;
    logic         dr;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  byte  grant_q[$];

  localparam logic [127:0] LA = {16{8'hA5}};
  localparam logic [127:0] LB = {16{8'h5A}};
  localparam logic [127:0] W  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] W2 = {4{32'hDEADBEEF}};

  pmem_arbiter dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  // A D-cache read and write together is illegal from the cache side.
  always @(posedge clk)
    if (reset_n)
      assert (!(dcache_pmem_read && dcache_pmem_write))
        else $error("protocol violation: dcache read and write asserted together");

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    icache_pmem_read    = v.icr;
    icache_pmem_address = v.ica;
    dcache_pmem_read    = v.dcr;
    dcache_pmem_write   = v.dcw;
    dcache_pmem_address = v.dca;
    dcache_pmem_wdata   = v.dcwd;
    pmem_rdata          = v.prd;
    pmem_resp           = v.presp;
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, " pmem_read"},    {127'd0, pmem_read},        {127'd0, e.rd});
    chk({tag, " pmem_write"},   {127'd0, pmem_write},       {127'd0, e.wr});
    chk({tag, " pmem_address"}, {112'd0, pmem_address},     {112'd0, e.addr});
    chk({tag, " pmem_wdata"},   pmem_wdata,                 e.wd);
    chk({tag, " icache_rdata"}, icache_pmem_rdata,          e.rdata);
    chk({tag, " dcache_rdata"}, dcache_pmem_rdata,          e.rdata);
    chk({tag, " icache_resp"},  {127'd0, icache_pmem_resp}, {127'd0, e.ir});
    chk({tag, " dcache_resp"},  {127'd0, dcache_pmem_resp}, {127'd0, e.dr});
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, check mid-cycle.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    apply(v);
    sb.push_back('{rd: v.e_rd, wr: v.e_wr, addr: v.e_addr, wd: v.e_wd,
                   rdata: v.prd, ir: v.e_ir, dr: v.e_dr});
    @(negedge clk);
    e = sb.pop_front();
    check_outs(tag, e);
  endtask

  function automatic vec_t mk(logic icr, logic [15:0] ica, logic dcr, logic dcw,
                              logic [15:0] dca, logic [127:0] dcwd, logic [127:0] prd,
                              logic presp, logic e_rd, logic e_wr, logic [15:0] e_addr,
                              logic [127:0] e_wd, logic e_ir, logic e_dr);
    vec_t v;
    v.icr = icr; v.ica = ica; v.dcr = dcr; v.dcw = dcw; v.dca = dca; v.dcwd = dcwd;
    v.prd = prd; v.presp = presp; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  vec_t tbl[19];
  vec_t idle_v, tie_v;

  initial begin
    //          icr ica       dcr dcw dca       dcwd prd presp| rd wr addr      wd  ir dr
    // D-cache write-back, two wait cycles then resp
    tbl[0]  = mk(0, 16'h0000, 0, 1, 16'h4440, W,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[1]  = mk(0, 16'h0000, 0, 1, 16'h4440, W,  0,  0,   0, 1, 16'h4440, W,  0, 0);
    tbl[2]  = mk(0, 16'h0000, 0, 1, 16'h4440, W,  LB, 0,   0, 1, 16'h4440, W,  0, 0);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 16'h4440, W,  0,  1,   0, 1, 16'h4440, W,  0, 1);
    tbl[4]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    // Lone I-cache read of 0x1230, memory answers on the third command cycle
    tbl[5]  = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[6]  = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,  0,   1, 0, 16'h1230, 0,  0, 0);
    tbl[7]  = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,  0,   1, 0, 16'h1230, 0,  0, 0);
    tbl[8]  = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  LA, 1,   1, 0, 16'h1230, 0,  1, 0);
    tbl[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    // Tie: D-cache first, then idle turnaround, then I-cache
    tbl[10] = mk(1, 16'h1230, 1, 0, 16'h2000, W2, 0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[11] = mk(1, 16'h1230, 1, 0, 16'h2000, W2, LB, 1,   1, 0, 16'h2000, W2, 0, 1);
    tbl[12] = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[13] = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  LA, 1,   1, 0, 16'h1230, 0,  1, 0);
    // pmem_resp while idle is ignored, arbiter still grants normally afterwards
    tbl[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  LB, 1,   0, 0, 16'h0000, 0,  0, 0);
    tbl[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[16] = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);
    tbl[17] = mk(1, 16'h1230, 0, 0, 16'h0000, 0,  LA, 1,   1, 0, 16'h1230, 0,  1, 0);
    tbl[18] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,  0,   0, 0, 16'h0000, 0,  0, 0);

    idle_v = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    tie_v  = mk(1, 16'h1230, 1, 0, 16'h2000, W2, 0, 0, 0, 0, 16'h0000, 0, 0, 0);

    reset_n = 1'b0;
    apply(idle_v);
    pmem_resp = 1'b1;
    #2;
    check_outs("reset", '{rd: 0, wr: 0, addr: 0, wd: 0, rdata: 0, ir: 0, dr: 0});
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-transfer while the D-cache owns the port.
    step("rst_req", mk(0, 16'h0000, 1, 0, 16'h3330, W, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    #1;
    chk("rst_pre pmem_read", {127'd0, dcache_pmem_resp & pmem_read}, {127'd0, 1'b1});
    reset_n = 1'b0;
    #1;
    check_outs("rst_mid", '{rd: 0, wr: 0, addr: 0, wd: 0, rdata: 0, ir: 0, dr: 0});
    @(negedge clk);
    apply(idle_v);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("post_rst%0d", i), idle_v);

    // Repeated ties; expected grant pushed when the tie is driven.
    for (int r = 0; r < 4; r++) begin
      byte got, want;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      grant_q.push_back((r % 2 == 0) ? "D" : "I");
`else
      grant_q.push_back("D");
`endif
      step($sformatf("tie%0d_req", r), tie_v);
      @(posedge clk); #1;
      pmem_resp = 1'b1;
      @(negedge clk);
      if (dcache_pmem_resp && !icache_pmem_resp && pmem_address == 16'h2000) got = "D";
      else if (icache_pmem_resp && !dcache_pmem_resp && pmem_address == 16'h1230) got = "I";
      else got = "?";
      want = grant_q.pop_front();
      chk($sformatf("tie%0d grant", r), {120'd0, got}, {120'd0, want});
      step($sformatf("tie%0d_idle", r), idle_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
